// File: rtl/snake_motion_unit.sv
// Snake motion unit: direction register, body buffer, move/grow,
// self-collision scan, apple detection and a registered render read port.
module snake_motion_unit #(
  parameter int MAX_LEN = 16,
  parameter int GRID_W  = 6,
  parameter int GRID_H  = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init,
  input  logic [3:0] buttons,
  input  logic       move,
  input  logic       grow,
  input  logic [5:0] apple,
  input  logic [3:0] rd_addr,
  output logic [5:0] rd_pos,
  output logic [5:0] head,
  output logic [4:0] size,
  output logic [3:0] direction,
  output logic       busy,
  output logic       done,
  output logic       ate,
  output logic       collided
);

  typedef enum logic [1:0] {IDLE, CHECK, FIN} state_t;

  state_t     state, state_n;
  logic [5:0] body [MAX_LEN];
  logic [3:0] last_dir;
  logic [3:0] opp;
  logic [4:0] k;
  logic [2:0] row, col, row_n, col_n;
  logic [5:0] new_head;
  logic       start, last_k, btn_ok;

  assign head     = body[0];
  assign busy     = (state != IDLE);
  assign row      = body[0][5:3];
  assign col      = body[0][2:0];
  assign new_head = {row_n, col_n};

  always_comb begin
    row_n = row;
    col_n = col;
    unique case (1'b1)
      direction[3]: row_n = (row == 3'd0) ? 3'(GRID_H - 1) : row - 3'd1;
      direction[2]: row_n = (row == 3'(GRID_H - 1)) ? 3'd0 : row + 3'd1;
      direction[1]: col_n = (col == 3'd0) ? 3'(GRID_W - 1) : col - 3'd1;
      direction[0]: col_n = (col == 3'(GRID_W - 1)) ? 3'd0 : col + 3'd1;
      default: ;
    endcase
  end

  // Reversal is judged against the last executed move, not the pending one.
  assign opp    = {last_dir[2], last_dir[3], last_dir[0], last_dir[1]};
  assign btn_ok = $onehot(buttons) && !(size > 5'd1 && buttons == opp);
  assign last_k = (size <= 5'd1) || (k >= 5'(size - 5'd1));

  always_comb begin
    state_n = state;
    start   = 1'b0;
    unique case (state)
      IDLE: if (move) begin
        state_n = CHECK;
        start   = 1'b1;
      end
      CHECK: if (last_k) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (init) begin
      state_n = IDLE;
      start   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= 6'h00;
      body[0]   <= 6'h12;
      size      <= 5'd1;
      direction <= 4'b0001;
      last_dir  <= 4'b0001;
      ate       <= 1'b0;
      collided  <= 1'b0;
      done      <= 1'b0;
      rd_pos    <= 6'h00;
      k         <= 5'd1;
    end else if (init) begin
      for (int i = 0; i < MAX_LEN; i++) body[i] <= 6'h00;
      body[0]   <= 6'h12;
      size      <= 5'd1;
      direction <= 4'b0001;
      last_dir  <= 4'b0001;
      ate       <= 1'b0;
      collided  <= 1'b0;
      done      <= 1'b0;
      rd_pos    <= 6'h00;
      k         <= 5'd1;
    end else begin
      done <= (state == FIN);
      if (btn_ok) direction <= buttons;
      if (start) begin
        for (int i = 1; i < MAX_LEN; i++) body[i] <= body[i-1];
        body[0]  <= new_head;
        last_dir <= direction;
        if (grow && size < 5'(MAX_LEN)) size <= size + 5'd1;
        ate <= (new_head == apple);
        k   <= 5'd1;
      end else if (state == CHECK) begin
        if (size > 5'd1 && body[k[3:0]] == body[0]) collided <= 1'b1;
        k <= k + 5'd1;
      end
      rd_pos <= ({1'b0, rd_addr} < size) ? body[rd_addr] : 6'h3F;
    end
  end

endmodule

// File: tb/tb_snake_motion_unit.sv
// Directed bench for snake_motion_unit: move table plus hand sequences
// for read port, direction rules, grow limit and init abort.
module tb_snake_motion_unit;

  logic       clock = 1'b0;
  logic       reset, init, move, grow;
  logic [3:0] buttons, rd_addr;
  logic [5:0] apple;
  logic [5:0] rd_pos, head;
  logic [4:0] size;
  logic [3:0] direction;
  logic       busy, done, ate, collided;

  int passed = 0;
  int total  = 0;

  snake_motion_unit dut (
    .clock(clock), .reset(reset), .init(init), .buttons(buttons),
    .move(move), .grow(grow), .apple(apple), .rd_addr(rd_addr),
    .rd_pos(rd_pos), .head(head), .size(size), .direction(direction),
    .busy(busy), .done(done), .ate(ate), .collided(collided)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         do_init;
    logic [3:0] btn;
    bit         g;
    logic [5:0] apl;
    logic [5:0] e_head;
    int         e_size;
    logic [3:0] e_dir;
    bit         e_ate;
    bit         e_coll;
    int         e_lat;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_init;
    init = 1'b1;
    tick;
    init = 1'b0;
  endtask

  task automatic press(input logic [3:0] b);
    buttons = b;
    tick;
    buttons = 4'b0000;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_move(input bit g, output int lat);
    move = 1'b1;
    grow = g;
    tick;
    move = 1'b0;
    grow = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, nd;
    logic [5:0] exp_rd [4];
    exp_rd[0] = 6'h15; exp_rd[1] = 6'h14;
    exp_rd[2] = 6'h13; exp_rd[3] = 6'h12;

    tbl[0]  = '{0, 4'b0000, 0, 6'h13, 6'h13, 1, 4'b0001, 1, 0, 2};
    tbl[1]  = '{0, 4'b0000, 0, 6'h13, 6'h14, 1, 4'b0001, 0, 0, 2};
    tbl[2]  = '{0, 4'b0000, 0, 6'h13, 6'h15, 1, 4'b0001, 0, 0, 2};
    tbl[3]  = '{0, 4'b0000, 0, 6'h13, 6'h10, 1, 4'b0001, 0, 0, 2};
    tbl[4]  = '{1, 4'b0000, 1, 6'h13, 6'h13, 2, 4'b0001, 1, 0, 2};
    tbl[5]  = '{0, 4'b0000, 1, 6'h13, 6'h14, 3, 4'b0001, 0, 0, 3};
    tbl[6]  = '{0, 4'b0000, 1, 6'h13, 6'h15, 4, 4'b0001, 0, 0, 4};
    tbl[7]  = '{0, 4'b0000, 1, 6'h13, 6'h10, 5, 4'b0001, 0, 0, 5};
    tbl[8]  = '{0, 4'b0100, 0, 6'h13, 6'h18, 5, 4'b0100, 0, 0, 5};
    tbl[9]  = '{0, 4'b0010, 0, 6'h13, 6'h1D, 5, 4'b0010, 0, 0, 5};
    tbl[10] = '{0, 4'b1000, 0, 6'h13, 6'h15, 5, 4'b1000, 0, 1, 5};
    tbl[11] = '{0, 4'b0000, 0, 6'h0D, 6'h0D, 5, 4'b1000, 1, 1, 5};

    reset = 1'b1; init = 1'b0; move = 1'b0; grow = 1'b0;
    buttons = 4'b0000; rd_addr = 4'd0; apple = 6'h13;
    tick;
    tick;
    reset = 1'b0;
    chk("rst size", size, 1);
    chk("rst head", head, 6'h12);
    chk("rst dir", direction, 4'b0001);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst ate", ate, 0);
    chk("rst coll", collided, 0);
    chk("rst rd_pos", rd_pos, 0);
    tick;
    chk("rd head", rd_pos, 6'h12);
    rd_addr = 4'd1;
    tick;
    chk("rd beyond", rd_pos, 6'h3F);
    rd_addr = 4'd0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_init) do_init;
      apple = tbl[i].apl;
      if (tbl[i].btn != 4'b0000) press(tbl[i].btn);
      do_move(tbl[i].g, lat);
      chk($sformatf("v%0d head", i), head, tbl[i].e_head);
      chk($sformatf("v%0d size", i), size, tbl[i].e_size);
      chk($sformatf("v%0d dir", i), direction, tbl[i].e_dir);
      chk($sformatf("v%0d ate", i), ate, tbl[i].e_ate);
      chk($sformatf("v%0d coll", i), collided, tbl[i].e_coll);
      chk($sformatf("v%0d lat", i), lat, tbl[i].e_lat);
    end

    do_init;
    chk("init coll", collided, 0);
    chk("init head", head, 6'h12);
    chk("init size", size, 1);
    chk("init dir", direction, 4'b0001);

    move = 1'b1;
    tick;
    chk("busy after move", busy, 1);
    tick;
    move = 1'b0;
    wait_done(lat);
    chk("busy move lat", lat, 1);
    tick;
    tick;
    chk("busy move head", head, 6'h13);
    chk("busy move idle", busy, 0);

    do_init;
    for (int i = 0; i < 3; i++) do_move(1'b1, lat);
    chk("grow3 size", size, 4);
    chk("grow3 lat", lat, 4);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 4'(a);
      tick;
      chk($sformatf("rd %0d", a), rd_pos, exp_rd[a]);
    end
    rd_addr = 4'd4;
    tick;
    chk("rd 4", rd_pos, 6'h3F);

    press(4'b0010);
    chk("dir rev blocked", direction, 4'b0001);
    press(4'b1000);
    chk("dir up", direction, 4'b1000);
    press(4'b1100);
    chk("dir multi hold", direction, 4'b1000);

    rd_addr = 4'd0;
    move = 1'b1;
    tick;
    move = 1'b0;
    chk("rd preshift", rd_pos, 6'h15);
    chk("head up", head, 6'h0D);
    wait_done(lat);
    chk("up lat", lat, 4);

    move = 1'b1;
    tick;
    move = 1'b0;
    tick;
    do_init;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) nd++;
      tick;
    end
    chk("abort done", nd, 0);
    chk("abort busy", busy, 0);
    chk("abort size", size, 1);
    chk("abort head", head, 6'h12);

    press(4'b0010);
    chk("dir rev size1", direction, 4'b0010);

    do_init;
    for (int i = 0; i < 15; i++) do_move(1'b1, lat);
    chk("size16", size, 16);
    do_move(1'b1, lat);
    chk("size16 hold", size, 16);
    chk("size16 lat", lat, 16);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
